// File: rtl/pattern_seq_ctrl.sv
// Pattern sequencer: owns the single-port LED pattern RAM, paces playback by tick, start/stop/step, loop window.
// Latency: a read issued in cycle T updates leds/pc from T+1; host writes complete in the cycle wr_valid && wr_ready.
// Backpressure: playback reads own the RAM; wr_ready drops in any read cycle. Optional build macro: PATSEQ_ONESHOT_EN.
module pattern_seq_ctrl #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 21,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic [AW-1:0]    loop_start,
  input  logic [AW-1:0]    loop_end,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] leds,
  output logic [AW-1:0]    pc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t           state;
  logic [AW-1:0]    win_start;
  logic [AW-1:0]    win_end;
  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    san_start;
  logic [AW-1:0]    san_end;
  logic             rd_tick;
  logic             rd_step;
  logic             rd_en;
  logic             at_end;
  logic [AW-1:0]    pc_adv;
  logic             wr_fire;

  // Clamp the requested window into the RAM; an inverted window collapses to one entry.
  always_comb begin
    san_start = loop_start;
    san_end   = loop_end;
    if (int'(loop_start) >= DEPTH) begin
      san_start = '0;
    end
    if (int'(loop_end) >= DEPTH) begin
      san_end = LAST;
    end
    if (san_end < san_start) begin
      san_end = san_start;
    end
  end

  // Decide whether the RAM is read this cycle; start outranks stop and step.
  always_comb begin
    rd_tick = (state == RUN) && tick && !stop && !start;
    rd_step = (state == HOLD) && step && !start;
    rd_en   = start || rd_tick || rd_step;
  end

  // Next program counter inside the loop window.
  always_comb begin
    at_end = (pc == win_end);
    pc_adv = at_end ? win_start : (pc + 1'b1);
  end

  // Host port only gets the RAM in cycles with no playback read; out-of-range writes are swallowed.
  always_comb begin
    wr_ready = !rd_en;
    wr_fire  = wr_valid && wr_ready && (int'(wr_addr) < DEPTH);
  end

  assign busy = (state == RUN);

  // Pattern RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_addr] <= wr_data;
    end
  end

`ifdef PATSEQ_ONESHOT_EN
  logic done_q;
  assign done = done_q;
`else
  assign done = 1'b0;
`endif

  // Playback FSM: owns state, window, pc and the registered leds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      leds      <= '0;
      pc        <= '0;
      win_start <= '0;
      win_end   <= LAST;
`ifdef PATSEQ_ONESHOT_EN
      done_q    <= 1'b0;
`endif
    end else begin
`ifdef PATSEQ_ONESHOT_EN
      done_q <= 1'b0;
`endif
      if (start) begin
        // Restart from any state: show the first entry now and park pc on it.
        win_start <= san_start;
        win_end   <= san_end;
        leds      <= mem[san_start];
        pc        <= san_start;
        state     <= RUN;
      end else begin
        case (state)
          IDLE: begin
            // Nothing moves until start.
          end
          RUN: begin
            if (stop) begin
              state <= HOLD;
            end else if (tick) begin
              leds <= mem[pc];
`ifdef PATSEQ_ONESHOT_EN
              if (at_end) begin
                pc     <= win_start;
                state  <= HOLD;
                done_q <= 1'b1;
              end else begin
                pc <= pc + 1'b1;
              end
`else
              pc <= pc_adv;
`endif
            end
          end
          HOLD: begin
            // Single-step always wraps, even in the one-shot build.
            if (step) begin
              leds <= mem[pc];
              pc   <= pc_adv;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/pattern_seq_ctrl.md
Name: pattern_seq_ctrl

Overview:
Controller that owns the LED pattern memory and sequences it: holds the program counter, paces playback from an external tick, and supports start/stop/single-step with a programmable loop window. It also arbitrates the single-port pattern RAM between playback reads and a host write port, so patterns can be reloaded at run time. It sits between the clock-divider tick source and the board LEDs.

Parameters:
WIDTH, 3, pattern/LED width in bits
DEPTH, 21, number of pattern entries
AW, 5, address width (must satisfy 2^AW >= DEPTH)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick  in  1  one-cycle pacing pulse
start  in  1  pulse: latch loop window, begin playback
stop  in  1  pulse: pause playback
step  in  1  pulse: advance one entry while paused
loop_start  in  AW  first entry of loop window (sampled on start)
loop_end  in  AW  last entry of loop window (sampled on start)
wr_valid  in  1  host write request
wr_ready  out  1  host write accepted this cycle
wr_addr  in  AW  host write address
wr_data  in  WIDTH  host write data
leds  out  WIDTH  registered pattern output
pc  out  AW  current entry index
busy  out  1  high in RUN
done  out  1  one-cycle end-of-sequence pulse (oneshot build only)

Behaviour:
- Reset (async, rst_n=0): state IDLE, leds=0, pc=0, busy=0, done=0; window regs start=0, end=DEPTH-1; RAM contents are not reset.
- States: IDLE, RUN, HOLD.
- Window sanitise on start: start>=DEPTH -> 0; end>=DEPTH -> DEPTH-1; end<start -> end=start, giving a one-entry loop.
- IDLE: start -> read issued at sanitised start, pc=start, next state RUN. tick/step/stop ignored.
- RUN: tick -> read issued at pc. Next cycle: leds=MEM[pc]; pc=(pc==end)?start:pc+1. stop -> HOLD. Stop and tick in the same cycle: stop wins, no read.
- HOLD: leds and pc held. step -> one read and advance, as for a RUN tick, and the state stays HOLD. start -> RUN.
- start in RUN or HOLD restarts from the new window and issues an immediate read. start beats stop and step in the same cycle.
- Read latency: read issued in cycle T; leds and pc update visible from T+1.
- Arbitration: RAM is single port. A playback read has priority. wr_ready = !read_this_cycle, a combinational function of state and the tick/step/start inputs. A write completes when wr_valid && wr_ready.
- Writes with wr_addr>=DEPTH are accepted (ready honoured) and dropped.
- A write to the entry being read in a blocked cycle lands later, so playback sees the old data for that read.
- busy=1 exactly in RUN.

Optional Feature:
PATSEQ_ONESHOT_EN.
- Defined: in RUN, the advance past end goes to HOLD instead of wrapping. pc goes to start, done pulses high for one cycle alongside the leds update of the end entry, and leds hold MEM[end]. step in HOLD still wraps normally.
- Undefined: the window always wraps, and done is tied to 0.

Test Plan:
- Reset, then load MEM[0..20]=0,1,2,0,1,2,… via the write port with tick idle (wr_ready=1 every cycle). start with window 0..20, tick every 4 cycles -> leds 0,1,2,0,…; pc wraps 20->0.
- Window 3..5 -> leds sequence MEM[3],MEM[4],MEM[5],MEM[3]; window 7..2 -> fixed at MEM[7], pc stays 7.
- stop and tick in the same cycle -> no leds change, state HOLD. Three step pulses -> three advances. Then start -> busy=1.
- wr_valid held high with a tick in cycle T -> wr_ready=0 at T, write completes at T+1. Write to addr 25 -> accepted, and MEM is unchanged on readback.
- rst_n asserted mid-RUN (asynchronously, between clock edges) -> leds=0, pc=0, busy=0 immediately. After release, tick is ignored until start.
- With PATSEQ_ONESHOT_EN, window 0..2 -> leds MEM[0],MEM[1],MEM[2]; done pulses once; state HOLD, busy=0; further ticks cause no change.
